// File: rtl/layer_output_sequencer.sv
// Captures one word per upstream neuron, then replays them in index order on a ready/valid stream.
// Optional ARGMAX_EN build adds a signed running-max tracker that reports the winning index.
module layer_output_sequencer #(
  parameter  int no_neuron  = 10,
  parameter  int data_width = 16,
  localparam int IDX_W      = $clog2(no_neuron)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [no_neuron-1:0]            valid_output,
  input  logic [no_neuron*data_width-1:0] neuron_out,
  output logic [data_width-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            overrun,
  output logic [IDX_W-1:0]                class_idx,
  output logic                            class_valid
);

  typedef enum logic {COLLECT = 1'b0, SEND = 1'b1} state_t;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(no_neuron - 1);

  state_t                       state_q, state_d;
  logic [no_neuron-1:0]         mask_q, mask_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic signed [data_width-1:0] cap_q [no_neuron];
  logic signed [data_width-1:0] cap_d [no_neuron];
  logic [data_width-1:0]        out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic                         busy_q, busy_d;
  logic                         overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    cap_d     = cap_q;
    case (state_q)
      COLLECT: begin
        for (int i = 0; i < no_neuron; i++) begin
          if (valid_output[i]) cap_d[i] = neuron_out[i*data_width +: data_width];
        end
        if (|(valid_output & mask_q)) overrun_d = 1'b1;
        mask_d = mask_q | valid_output;
        if (&mask_d) begin
          state_d = SEND;
          idx_d   = '0;
          mask_d  = '0;
        end
      end
      SEND: begin
        if (|valid_output) overrun_d = 1'b1;
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = COLLECT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Outputs are precomputed from next-state so they leave the block registered.
    out_valid_d = (state_d == SEND);
    busy_d      = out_valid_d;
    out_last_d  = out_valid_d && (idx_d == LAST_IDX);
    out_data_d  = out_valid_d ? cap_d[idx_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= COLLECT;
      mask_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    cap_q <= cap_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

`ifdef ARGMAX_EN
  logic signed [data_width-1:0] max_q, max_d, beat_w;
  logic [IDX_W-1:0]             max_idx_q, max_idx_d;
  logic [IDX_W-1:0]             class_idx_q, class_idx_d;
  logic                         class_valid_q, class_valid_d;
  logic                         take;

  always_comb begin
    max_d         = max_q;
    max_idx_d     = max_idx_q;
    class_idx_d   = class_idx_q;
    class_valid_d = 1'b0;
    beat_w        = cap_q[idx_q];
    // Strictly greater keeps the earliest index on ties.
    take          = (idx_q == '0) || (beat_w > max_q);
    if (state_q == SEND && out_ready) begin
      if (take) begin
        max_d     = beat_w;
        max_idx_d = idx_q;
      end
      if (idx_q == LAST_IDX) begin
        class_idx_d   = take ? idx_q : max_idx_q;
        class_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      class_idx_q   <= '0;
      class_valid_q <= 1'b0;
    end else begin
      class_idx_q   <= class_idx_d;
      class_valid_q <= class_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    max_q     <= max_d;
    max_idx_q <= max_idx_d;
  end

  assign class_idx   = class_idx_q;
  assign class_valid = class_valid_q;
`else
  assign class_idx   = '0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_output_sequencer.sv
// Bench for layer_output_sequencer: table of capture scenarios plus hand-built stall,
// overrun and mid-stream reset sequences; beats are checked against a scoreboard queue.
module tb_layer_output_sequencer;
  localparam int NN = 10;
  localparam int DW = 16;
  localparam int IW = $clog2(NN);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NN-1:0]     valid_output = '0;
  logic [NN*DW-1:0]  neuron_out = '0;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic              busy;
  logic              overrun;
  logic [IW-1:0]     class_idx;
  logic              class_valid;

  layer_output_sequencer #(.no_neuron(NN), .data_width(DW)) dut (
    .clk(clk), .rst(rst), .valid_output(valid_output), .neuron_out(neuron_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .overrun(overrun), .class_idx(class_idx), .class_valid(class_valid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { logic [NN*DW-1:0] words; int order; int exp_max; } vec_t;

  beat_t sbq[$];
  vec_t  tbl[5];
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every accepted beat must match the head of the queue.
  always @(negedge clk) begin : mon
    beat_t b;
    if (rst && out_valid && out_ready) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got data %0h, expected no beat", out_data);
      end else begin
        n_chk--;
        b = sbq.pop_front();
        chk("beat_data", out_data, b.data);
        chk("beat_last", out_last, b.last);
        chk("beat_busy", busy, 1);
      end
    end
  end

  task automatic push_words(input logic [NN*DW-1:0] w);
    beat_t b;
    for (int i = 0; i < NN; i++) begin
      b.data = w[i*DW +: DW];
      b.last = (i == NN - 1);
      sbq.push_back(b);
    end
  endtask

  // order 0: all strobes in one cycle; 1: neuron i at cycle i; 2: reverse order.
  task automatic apply(input logic [NN*DW-1:0] w, input int order);
    int i;
    push_words(w);
    neuron_out = w;
    if (order == 0) begin
      valid_output = '1;
      tick();
      valid_output = '0;
    end else begin
      for (int k = 0; k < NN; k++) begin
        i = (order == 1) ? k : NN - 1 - k;
        valid_output = NN'(1) << i;
        tick();
        valid_output = '0;
        if (k < NN - 1) begin
          @(negedge clk);
          chk("collect_no_valid", out_valid, 0);
        end
      end
    end
    @(negedge clk);
    chk("first_valid", out_valid, 1);
    chk("first_busy", busy, 1);
  endtask

  task automatic drain(input int exp_max, input logic exp_ovr);
    int c;
    c = 0;
    while (sbq.size() > 0 && c < 100) begin
      @(posedge clk);
      c++;
    end
    n_chk++;
    if (sbq.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d beats pending, expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
    chk("end_valid", out_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_last", out_last, 0);
    chk("end_overrun", overrun, exp_ovr);
`ifdef ARGMAX_EN
    chk("class_valid_pulse", class_valid, 1);
    chk("class_idx", class_idx, exp_max);
    @(negedge clk);
    chk("class_valid_drop", class_valid, 0);
    chk("class_idx_hold", class_idx, exp_max);
`else
    chk("class_valid_off", class_valid, 0);
    chk("class_idx_off", class_idx, 0);
    if (exp_max < 0) $display("note: negative argmax expectation %0d", exp_max);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NN*DW-1:0] w;

    for (int i = 0; i < NN; i++) begin
      tbl[0].words[i*DW +: DW] = 16'(i * 256);
      tbl[2].words[i*DW +: DW] = 16'h0000;
      tbl[3].words[i*DW +: DW] = 16'hFF9C;
      tbl[4].words[i*DW +: DW] = 16'(16'h0A00 - i * 256);
    end
    tbl[0].order = 0; tbl[0].exp_max = 9;
    tbl[1] = tbl[0];  tbl[1].order = 1;
    tbl[2].words[0*DW +: DW] = 16'hFFFB;
    tbl[2].words[1*DW +: DW] = 16'h0003;
    tbl[2].words[2*DW +: DW] = 16'h7000;
    tbl[2].words[3*DW +: DW] = 16'hFFFF;
    tbl[2].words[4*DW +: DW] = 16'h7000;
    tbl[2].order = 0; tbl[2].exp_max = 2;
    tbl[3].words[7*DW +: DW] = 16'hFFFF;
    tbl[3].order = 2; tbl[3].exp_max = 7;
    tbl[4].order = 2; tbl[4].exp_max = 0;

    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", out_data, 0);
    chk("rst_class_valid", class_valid, 0);
    chk("rst_class_idx", class_idx, 0);
    tick();
    rst = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) begin
      apply(tbl[k].words, tbl[k].order);
      drain(tbl[k].exp_max, 1'b0);
    end

    // Backpressure while beat 4 is on the bus.
    out_ready = 1'b0;
    apply(tbl[0].words, 0);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_data", out_data, 16'h0400);
      chk("stall_valid", out_valid, 1);
      chk("stall_last", out_last, 0);
    end
    tick();
    out_ready = 1'b1;
    drain(9, 1'b0);

    // Strobe arriving during SEND.
    apply(tbl[0].words, 0);
    repeat (5) tick();
    @(negedge clk);
    chk("ovr_before", overrun, 0);
    valid_output = NN'(4);
    neuron_out = {NN{16'hDEAD}};
    tick();
    valid_output = '0;
    @(negedge clk);
    chk("ovr_send", overrun, 1);
    drain(9, 1'b1);

    // Double strobe of neuron 3 during COLLECT; second value must win.
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("ovr_cleared", overrun, 0);
    neuron_out = {NN{16'h1111}};
    valid_output = NN'(8);
    tick();
    valid_output = '0;
    @(negedge clk);
    chk("ovr_single", overrun, 0);
    chk("collect_partial", out_valid, 0);
    w = tbl[0].words;
    w[3*DW +: DW] = 16'h3333;
    apply(w, 0);
    chk("ovr_double", overrun, 1);

    // Reset right after beat 5 is accepted.
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_data", out_data, 0);
    tick();
    apply(tbl[0].words, 0);
    drain(9, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
